// File: rtl/seg_pkg.sv
// seg_pkg: shared types, default sizing and helpers for segment_sequencer.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        OUT
    } seg_state_e;

    localparam int SEG_NUM_SEG_DEF    = 8;
    localparam int SEG_DP_LATENCY_DEF = 2;
    localparam int SEG_W_DEF          = 32;

    // The wait timer has to hold the largest supported DP_LATENCY, which is 15.
    localparam int SEG_TMR_W = 4;

    // Width of a segment index. It is never narrower than one bit.
    function automatic int seg_idx_width(input int num_seg);
        return (num_seg <= 2) ? 1 : $clog2(num_seg);
    endfunction

endpackage

// File: rtl/seg_wait_timer.sv
// seg_wait_timer: loadable down-counter that times the datapath wait.
// The timer is loaded with the latency when a segment is issued. expired is
// high on the last wait cycle, which is the cycle where the count equals 1.
module seg_wait_timer
    import seg_pkg::*;
#(
    parameter int CW = SEG_TMR_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          clear,
    output logic          expired
);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: clear wins over load. The counter stops at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register. reset is active-low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == CW'(1));

endmodule

// File: rtl/segment_sequencer.sv
// segment_sequencer: runs NUM_SEG segments through a shared if/else datapath.
// Each segment goes through three steps:
//   - take one operand beat,
//   - wait DP_LATENCY cycles,
//   - present the result on the out stream.
// Optional build macro: SEG_CHECKSUM_EN adds a per-run XOR checksum output.
//
// state | meaning
// IDLE  | no run active, waiting for start
// ISSUE | src_ready high, waiting for the operand beat
// WAIT  | dp_* held, timer counting the datapath latency
// OUT   | result presented, waiting for out_ready
module segment_sequencer
    import seg_pkg::*;
#(
    parameter int  NUM_SEG    = SEG_NUM_SEG_DEF,
    parameter int  DP_LATENCY = SEG_DP_LATENCY_DEF,
    parameter int  W          = SEG_W_DEF,
    localparam int IW         = seg_idx_width(NUM_SEG)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    input  logic          src_valid,
    output logic          src_ready,
    input  logic [W-1:0]  src_input_bit,
    input  logic [W-1:0]  src_if_op,
    input  logic [W-1:0]  src_else_op,
    output logic [W-1:0]  dp_input_bit,
    output logic [W-1:0]  dp_if_op,
    output logic [W-1:0]  dp_else_op,
    input  logic [W-1:0]  dp_result,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [IW-1:0] out_idx
`ifdef SEG_CHECKSUM_EN
    ,
    output logic [W-1:0]  checksum
`endif
);

    localparam logic [IW-1:0]        LAST_IDX = IW'(NUM_SEG - 1);
    localparam logic [SEG_TMR_W-1:0] WAIT_LD  = SEG_TMR_W'(DP_LATENCY);

    seg_state_e    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          src_ready_q, src_ready_d;
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  dp_input_bit_q, dp_input_bit_d;
    logic [W-1:0]  dp_if_op_q, dp_if_op_d;
    logic [W-1:0]  dp_else_op_q, dp_else_op_d;
    logic [W-1:0]  out_data_q, out_data_d;
    logic [IW-1:0] out_idx_q, out_idx_d;
    logic          tmr_load, tmr_clear, tmr_expired;
    logic          src_fire, out_fire;

    // A handshake that coincides with abort is not counted.
    assign src_fire = src_valid && src_ready_q && !abort;
    assign out_fire = out_valid_q && out_ready && !abort;

    seg_wait_timer #(.CW(SEG_TMR_W)) u_wait_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (WAIT_LD),
        .clear    (tmr_clear),
        .expired  (tmr_expired)
    );

    // Next-state and next-output logic. All outputs come straight from flops.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        src_ready_d    = 1'b0;
        out_valid_d    = 1'b0;
        dp_input_bit_d = dp_input_bit_q;
        dp_if_op_d     = dp_if_op_q;
        dp_else_op_d   = dp_else_op_q;
        out_data_d     = out_data_q;
        out_idx_d      = out_idx_q;
        tmr_load       = 1'b0;
        tmr_clear      = 1'b0;

        if (state_q != IDLE && abort) begin
            state_d   = IDLE;
            busy_d    = 1'b0;
            tmr_clear = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        state_d     = ISSUE;
                        idx_d       = '0;
                        busy_d      = 1'b1;
                        src_ready_d = 1'b1;
                    end
                end
                ISSUE: begin
                    if (src_fire) begin
                        dp_input_bit_d = src_input_bit;
                        dp_if_op_d     = src_if_op;
                        dp_else_op_d   = src_else_op;
                        tmr_load       = 1'b1;
                        state_d        = WAIT;
                    end else begin
                        src_ready_d = 1'b1;
                    end
                end
                WAIT: begin
                    if (tmr_expired) begin
                        out_data_d  = dp_result;
                        out_idx_d   = idx_q;
                        out_valid_d = 1'b1;
                        state_d     = OUT;
                    end
                end
                OUT: begin
                    out_valid_d = 1'b1;
                    if (out_fire) begin
                        out_valid_d = 1'b0;
                        if (idx_q == LAST_IDX) begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            idx_d       = idx_q + 1'b1;
                            src_ready_d = 1'b1;
                            state_d     = ISSUE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // FSM and registered-output flops. reset is an active-low asynchronous reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            src_ready_q    <= 1'b0;
            out_valid_q    <= 1'b0;
            dp_input_bit_q <= '0;
            dp_if_op_q     <= '0;
            dp_else_op_q   <= '0;
            out_data_q     <= '0;
            out_idx_q      <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            src_ready_q    <= src_ready_d;
            out_valid_q    <= out_valid_d;
            dp_input_bit_q <= dp_input_bit_d;
            dp_if_op_q     <= dp_if_op_d;
            dp_else_op_q   <= dp_else_op_d;
            out_data_q     <= out_data_d;
            out_idx_q      <= out_idx_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign src_ready    = src_ready_q;
    assign out_valid    = out_valid_q;
    assign dp_input_bit = dp_input_bit_q;
    assign dp_if_op     = dp_if_op_q;
    assign dp_else_op   = dp_else_op_q;
    assign out_data     = out_data_q;
    assign out_idx      = out_idx_q;

`ifdef SEG_CHECKSUM_EN
    logic [W-1:0] csum_q, csum_d;

    // Run checksum. It clears when a start is accepted and folds in each
    // accepted result. After an abort it keeps its last value.
    always_comb begin
        csum_d = csum_q;
        if (state_q == IDLE && start && !abort) begin
            csum_d = '0;
        end else if (state_q == OUT && out_fire) begin
            csum_d = csum_q ^ out_data_q;
        end
    end

    // Checksum register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_segment_sequencer.sv
// tb_segment_sequencer: random and directed runs against a transaction-level model.
// The model tracks four things:
//   - run active or not,
//   - a segment in flight or not,
//   - the cycle when that segment's beat was accepted,
//   - its operands.
// Expected outputs follow from a few rules:
//   - out_valid comes DP_LATENCY+1 cycles after the beat,
//   - done comes one cycle after the final result is accepted.
`timescale 1ns/1ps
module tb_segment_sequencer;

    localparam int NUM_SEG    = 4;
    localparam int DP_LATENCY = 2;
    localparam int W          = 32;
    localparam int IW         = 2;
    localparam int PIPE_IDX   = (DP_LATENCY >= 2) ? DP_LATENCY - 2 : 0;

    logic          clk = 1'b0;
    logic          reset;
    logic          start, abort;
    logic          busy, done;
    logic          src_valid, src_ready;
    logic [W-1:0]  src_input_bit, src_if_op, src_else_op;
    logic [W-1:0]  dp_input_bit, dp_if_op, dp_else_op, dp_result;
    logic          out_valid, out_ready;
    logic [W-1:0]  out_data;
    logic [IW-1:0] out_idx;
`ifdef SEG_CHECKSUM_EN
    logic [W-1:0]  checksum;
`endif

    always #5 clk = ~clk;

    segment_sequencer #(.NUM_SEG(NUM_SEG), .DP_LATENCY(DP_LATENCY), .W(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .busy          (busy),
        .done          (done),
        .src_valid     (src_valid),
        .src_ready     (src_ready),
        .src_input_bit (src_input_bit),
        .src_if_op     (src_if_op),
        .src_else_op   (src_else_op),
        .dp_input_bit  (dp_input_bit),
        .dp_if_op      (dp_if_op),
        .dp_else_op    (dp_else_op),
        .dp_result     (dp_result),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_idx       (out_idx)
`ifdef SEG_CHECKSUM_EN
        ,
        .checksum      (checksum)
`endif
    );

    function automatic logic [W-1:0] seg_mux(input logic [W-1:0] ib, input logic [W-1:0] io,
                                             input logic [W-1:0] eo);
        return (ib != '0) ? io : eo;
    endfunction

    // Datapath stand-in: the mux result becomes valid DP_LATENCY cycles after its inputs settle.
    logic [W-1:0] dp_pipe [0:15];
    always @(posedge clk) begin
        dp_pipe[0] <= seg_mux(dp_input_bit, dp_if_op, dp_else_op);
        for (int i = 1; i < 16; i++) dp_pipe[i] <= dp_pipe[i-1];
    end
    assign dp_result = (DP_LATENCY == 1) ? seg_mux(dp_input_bit, dp_if_op, dp_else_op)
                                         : dp_pipe[PIPE_IDX];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    bit           m_busy, m_inflight, m_done;
    int           m_beats, m_idx, beat_cyc, m_done_cnt;
    logic [W-1:0] m_ib, m_io, m_eo, m_csum;

    int scn, hold_n, gap_n;
    bit abort_sent;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic bit m_ov();
        return m_inflight && ((cyc - beat_cyc) >= DP_LATENCY + 1);
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; m_inflight = 1'b0; m_done = 1'b0;
        m_beats = 0; m_idx = 0; beat_cyc = 0;
        m_ib = '0; m_io = '0; m_eo = '0; m_csum = '0;
    endtask

    task automatic check_reset_outputs();
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_src_ready", 32'(src_ready), 32'd0);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_dp_input_bit", dp_input_bit, 32'd0);
        check_val("rst_dp_if_op", dp_if_op, 32'd0);
        check_val("rst_dp_else_op", dp_else_op, 32'd0);
        check_val("rst_out_data", out_data, 32'd0);
        check_val("rst_out_idx", 32'(out_idx), 32'd0);
`ifdef SEG_CHECKSUM_EN
        check_val("rst_checksum", checksum, 32'd0);
`endif
    endtask

    // One clock: advance the model using the inputs held over the edge, then compare.
    task automatic step();
        logic p_start, p_abort, p_sv, p_or, p_ov;
        logic [W-1:0] p_ib, p_io, p_eo;
        p_start = start; p_abort = abort; p_sv = src_valid; p_or = out_ready;
        p_ib = src_input_bit; p_io = src_if_op; p_eo = src_else_op;
        p_ov = m_ov();
        @(posedge clk);
        #1;
        m_done = 1'b0;
        if (!m_busy) begin
            if (p_start && !p_abort) begin
                m_busy = 1'b1; m_beats = 0; m_inflight = 1'b0; m_csum = '0;
            end
        end else if (p_abort) begin
            m_busy = 1'b0; m_inflight = 1'b0;
        end else if (!m_inflight) begin
            if (p_sv) begin
                m_inflight = 1'b1; beat_cyc = cyc;
                m_ib = p_ib; m_io = p_io; m_eo = p_eo;
                m_idx = m_beats; m_beats++;
            end
        end else if (p_ov && p_or) begin
            m_csum = m_csum ^ seg_mux(m_ib, m_io, m_eo);
            m_inflight = 1'b0;
            if (m_idx == NUM_SEG - 1) begin
                m_busy = 1'b0; m_done = 1'b1; m_done_cnt++;
            end
        end
        cyc++;
        check_val("busy", 32'(busy), 32'(m_busy));
        check_val("done", 32'(done), 32'(m_done));
        check_val("src_ready", 32'(src_ready), 32'(m_busy && !m_inflight));
        check_val("out_valid", 32'(out_valid), 32'(m_ov()));
        check_val("dp_input_bit", dp_input_bit, m_ib);
        check_val("dp_if_op", dp_if_op, m_io);
        check_val("dp_else_op", dp_else_op, m_eo);
        if (m_ov()) begin
            check_val("out_data", out_data, seg_mux(m_ib, m_io, m_eo));
            check_val("out_idx", 32'(out_idx), 32'(m_idx));
        end
`ifdef SEG_CHECKSUM_EN
        check_val("checksum", checksum, m_csum);
`endif
    endtask

    task automatic set_inputs();
        bit ov;
        ov = m_ov();
        start = 1'b0; abort = 1'b0; src_valid = 1'b1; out_ready = 1'b1;
        src_input_bit = ($urandom_range(0, 1) == 0) ? '0 : W'($urandom);
        src_if_op = $urandom; src_else_op = $urandom;
        case (scn)
            0: begin
                src_input_bit = W'(1);
                src_if_op = W'(1) << m_beats;
            end
            1: begin
                if (ov && m_idx == 1 && hold_n < 5) begin out_ready = 1'b0; hold_n++; end
                if (m_busy && !m_inflight && m_beats == 2 && gap_n < 4) begin
                    src_valid = 1'b0; gap_n++;
                end
            end
            2: begin
                if (!abort_sent && m_inflight && m_idx == 2 && (cyc - beat_cyc) == 1) begin
                    abort = 1'b1; abort_sent = 1'b1;
                end
            end
            default: begin
                src_valid = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 3) != 0);
                start     = ($urandom_range(0, 7) == 0);
                abort     = ($urandom_range(0, 79) == 0);
            end
        endcase
    endtask

    task automatic do_run(input int s, input int max_cyc);
        int n, dut_dones, dones0, exp_dones;
        scn = s; hold_n = 0; gap_n = 0; abort_sent = 1'b0;
        dones0 = m_done_cnt; dut_dones = 0;
        set_inputs(); start = 1'b1; abort = 1'b0;
        step();
        n = 0;
        while (m_busy && n < max_cyc) begin
            set_inputs();
            step();
            if (done === 1'b1) dut_dones++;
            n++;
        end
        check_val("run_timeout", 32'(n >= max_cyc), 32'd0);
        start = 1'b0; abort = 1'b0; src_valid = 1'b0; out_ready = 1'b1;
        repeat (2) begin
            step();
            if (done === 1'b1) dut_dones++;
        end
        exp_dones = (s == 3) ? (m_done_cnt - dones0) : ((s == 2) ? 0 : 1);
        check_val("done_count", 32'(dut_dones), 32'(exp_dones));
        check_val("idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic reset_mid_out();
        int n;
        scn = 0;
        set_inputs(); start = 1'b1;
        step();
        n = 0;
        while (!(m_ov() && m_idx == 1) && n < 50) begin
            set_inputs();
            step();
            n++;
        end
        check_val("reach_out_idx1", 32'(n < 50), 32'd1);
        start = 1'b0; out_ready = 1'b0;
        #2 reset = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        @(posedge clk);
        #1;
        cyc++;
        check_reset_outputs();
        #2 reset = 1'b1;
        out_ready = 1'b1; src_valid = 1'b1;
        repeat (5) step();
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        src_valid = 1'b0; out_ready = 1'b0;
        src_input_bit = '0; src_if_op = '0; src_else_op = '0;
        m_done_cnt = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        #2 reset = 1'b1;
        repeat (2) step();

        // start together with abort in IDLE must not launch a run
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        step();

        do_run(0, 200);
        do_run(0, 200);
        do_run(1, 200);
        do_run(2, 200);
        do_run(0, 200);
        for (int r = 0; r < 25; r++) do_run(3, 400);
        reset_mid_out();
        do_run(3, 400);
        do_run(0, 200);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/segment_sequencer.md
SEGMENT_SEQUENCER -- requirements
Module: segment_sequencer

Interface
REQ-001 Parameter NUM_SEG, default 8, meaning number of segments per run (2..256).
REQ-002 Parameter DP_LATENCY, default 2, meaning cycles from stable datapath inputs to valid segment result (1..15).
REQ-003 Parameter W, default 32, meaning operand and result width.
REQ-004 clk  in  1  meaning the single clock; all state on its rising edge.
REQ-005 reset  in  1  meaning asynchronous, active-low reset.
REQ-006 start  in  1; abort  in  1  meaning run launch pulse and run cancel.
REQ-007 busy  out  1; done  out  1  meaning run in progress, and a one-cycle end-of-run pulse.
REQ-008 src_valid  in  1; src_ready  out  1; src_input_bit, src_if_op, src_else_op  in  W each  meaning the operand stream, one beat per segment.
REQ-009 dp_input_bit, dp_if_op, dp_else_op  out  W each; dp_result  in  W  meaning the shared if/else segment datapath port.
REQ-010 out_valid  out  1; out_ready  in  1; out_data  out  W; out_idx  out  clog2(NUM_SEG)  meaning the result stream.

Function
REQ-011 FSM states SHALL be IDLE, ISSUE, WAIT, OUT.
REQ-012 IDLE: start=1 SHALL go to ISSUE with segment index 0 and busy=1 from the next cycle.
REQ-013 ISSUE: src_ready=1; on src_valid&src_ready, operands SHALL be registered onto dp_* outputs, the wait counter loaded with DP_LATENCY, and the FSM SHALL go to WAIT.
REQ-014 src_valid low in ISSUE SHALL stall with no state change.
REQ-015 dp_* outputs SHALL hold stable from the issue edge until the next issue or reset.
REQ-016 WAIT SHALL last exactly DP_LATENCY cycles; on its last cycle, dp_result SHALL be captured into out_data with out_idx = segment index, and the FSM SHALL go to OUT.
REQ-017 OUT: out_valid=1, with out_data/out_idx stable until out_valid&out_ready.
REQ-018 On the OUT handshake, if index < NUM_SEG-1, the index SHALL increment and the FSM SHALL return to ISSUE; otherwise done SHALL pulse for one cycle, busy SHALL drop, and the FSM SHALL return to IDLE.
REQ-019 start SHALL be ignored when not in IDLE.
REQ-020 abort=1 in any non-IDLE state SHALL go to IDLE next cycle: no done pulse; pending result dropped; out_valid and src_ready low.
REQ-021 abort takes priority over a simultaneous src or out handshake; that handshake SHALL NOT count.
REQ-022 start and abort together in IDLE SHALL leave the FSM in IDLE.
REQ-023 Latency from src beat to out_valid SHALL be DP_LATENCY+1 cycles.
REQ-024 Peak throughput SHALL be one segment per DP_LATENCY+2 cycles.

Reset
REQ-025 reset low SHALL asynchronously force IDLE, index 0, and wait counter 0.
REQ-026 reset low SHALL force busy, done, src_ready, out_valid = 0 and dp_*, out_data, out_idx = 0.
REQ-027 Reset mid-run SHALL discard the run; there SHALL be no done pulse after release.

Configuration
REQ-028 With SEG_CHECKSUM_EN defined: output checksum (W) = XOR of all out_data accepted in the current run. It SHALL clear on start acceptance and be final in the done cycle. It SHALL reset to 0 and hold after abort.
REQ-029 Without SEG_CHECKSUM_EN: no checksum port and no accumulator logic.

Structure
REQ-030 Shared package seg_pkg SHALL hold the FSM state enum, the default NUM_SEG/DP_LATENCY/W constants, and the index-width function.
REQ-031 One sub-module, seg_wait_timer (loadable down-counter, done flag), SHALL implement the WAIT timing; all other logic stays in segment_sequencer.

Verification
REQ-032 NUM_SEG=4, DP_LATENCY=2, src always valid, out_ready=1, datapath modelled as mux -> 4 results, idx 0..3, each out_valid 3 cycles after its src beat; done pulses once.
REQ-033 out_ready low for 5 cycles on idx 1 -> out_data/out_idx held stable, src_ready stays 0, no beat lost.
REQ-034 src_valid low 4 cycles before idx 2 -> FSM holds ISSUE, dp_* unchanged from idx 1.
REQ-035 abort asserted in WAIT of idx 2 -> IDLE next cycle, no done, no out_valid; a new start runs from idx 0.
REQ-036 reset low in OUT of idx 1 -> all outputs 0 immediately; after release, idle with busy=0.
REQ-037 SEG_CHECKSUM_EN, results 0x1,0x2,0x4,0x8 -> checksum 0x0000000F at done; second run restarts from 0.
